// File: rtl/blit_patpix.sv
// blit_patpix: pattern byte serializer emitting 8/4/2-bit pixels MSB-first, one per STEP.
// Optional PATZERO output is built only when BLIT_PATZERO_EN is defined.
`default_nettype none

module blit_patpix (
  input  logic       MasterClock,
  input  logic       RESETL,
  input  logic [7:0] PATD,
  input  logic       PATLD,
  input  logic [1:0] PMODE,
  input  logic       PATREP,
  input  logic       STEP,
  output logic [7:0] PIXD,
  output logic       PIXVAL,
  output logic       PATREQ,
  output logic       STARVE
`ifdef BLIT_PATZERO_EN
  ,output logic      PATZERO
`endif
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  modeq_q, modeq_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  pixd_q, pixd_d;
  logic        pixval_q, pixval_d;
  logic        starve_q, starve_d;

  function automatic logic [2:0] ppb(input logic [1:0] mode);
    case (mode)
      2'b01:   ppb = 3'd2;
      2'b10:   ppb = 3'd4;
      default: ppb = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] pix_of(input logic [7:0] sr, input logic [1:0] mode);
    case (mode)
      2'b01:   pix_of = {4'b0, sr[7:4]};
      2'b10:   pix_of = {6'b0, sr[7:6]};
      default: pix_of = sr;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    hold_d   = hold_q;
    modeq_d  = modeq_q;
    cnt_d    = cnt_q;
    starve_d = 1'b0;

    // A load always wins; a STEP coinciding with it is either starved (EMPTY)
    // or absorbed by the discarded byte (FULL).
    if (PATLD) begin
      sr_d     = PATD;
      hold_d   = PATD;
      modeq_d  = PMODE;
      cnt_d    = ppb(PMODE);
      state_d  = S_FULL;
      starve_d = (state_q == S_EMPTY) && STEP;
    end else if (state_q == S_EMPTY) begin
      starve_d = STEP;
    end else if (STEP) begin
      if (cnt_q > 3'd1) begin
        cnt_d = cnt_q - 3'd1;
        case (modeq_q)
          2'b01:   sr_d = {sr_q[3:0], 4'b0};
          2'b10:   sr_d = {sr_q[5:0], 2'b0};
          default: sr_d = 8'h00;
        endcase
      end else if (PATREP) begin
        sr_d  = hold_q;
        cnt_d = ppb(modeq_q);
      end else begin
        state_d = S_EMPTY;
      end
    end

    pixval_d = (state_d == S_FULL);
    pixd_d   = pixval_d ? pix_of(sr_d, modeq_d) : 8'h00;
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state_q  <= S_EMPTY;
      sr_q     <= 8'h00;
      hold_q   <= 8'h00;
      modeq_q  <= 2'b00;
      cnt_q    <= 3'd0;
      pixd_q   <= 8'h00;
      pixval_q <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      hold_q   <= hold_d;
      modeq_q  <= modeq_d;
      cnt_q    <= cnt_d;
      pixd_q   <= pixd_d;
      pixval_q <= pixval_d;
      starve_q <= starve_d;
    end
  end

  assign PIXD   = pixd_q;
  assign PIXVAL = pixval_q;
  assign STARVE = starve_q;
  assign PATREQ = (state_q == S_EMPTY);

`ifdef BLIT_PATZERO_EN
  logic patzero_q;

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) patzero_q <= 1'b0;
    else         patzero_q <= pixval_d && (pixd_d == 8'h00);
  end

  assign PATZERO = patzero_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_blit_patpix.sv
// tb_blit_patpix: directed plus randomized stimulus, pixel-queue reference model, scoreboard monitor.
`default_nettype none

module tb_blit_patpix;

  logic       clk = 1'b0;
  logic       rstl;
  logic [7:0] patd;
  logic       patld;
  logic [1:0] pmode;
  logic       patrep;
  logic       step;
  logic [7:0] pixd;
  logic       pixval;
  logic       patreq;
  logic       starve;
  logic       patzero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blit_patpix dut (
    .MasterClock(clk),
    .RESETL     (rstl),
    .PATD       (patd),
    .PATLD      (patld),
    .PMODE      (pmode),
    .PATREP     (patrep),
    .STEP       (step),
    .PIXD       (pixd),
    .PIXVAL     (pixval),
    .PATREQ     (patreq),
    .STARVE     (starve)
`ifdef BLIT_PATZERO_EN
    ,.PATZERO   (patzero)
`endif
  );

`ifndef BLIT_PATZERO_EN
  assign patzero = 1'b0;
`endif

  // Reference model: pending pixels of the current byte, plus the held byte/mode for repeat.
  logic [7:0]  pend[$];
  logic [7:0]  m_hold;
  logic [1:0]  m_mode;
  logic [11:0] expq[$];

  function automatic logic [11:0] pack(input logic v, input logic r, input logic s,
                                       input logic z, input logic [7:0] d);
    return {v, r, s, z, d};
  endfunction

  task automatic split(input logic [7:0] b, input logic [1:0] mode);
    int bpp;
    bpp = (mode == 2'b01) ? 4 : (mode == 2'b10) ? 2 : 8;
    pend.delete();
    for (int k = 0; k < 8 / bpp; k++)
      pend.push_back(8'((int'(b) >> (8 - bpp * (k + 1))) & ((1 << bpp) - 1)));
  endtask

  // Drive one cycle of inputs and push the outputs expected after the next rising edge.
  task automatic drive(input logic ld, input logic [7:0] d, input logic [1:0] mode,
                       input logic rep, input logic st);
    logic was_empty, stv, v, z;
    logic [7:0] px;
    patld = ld; patd = d; pmode = mode; patrep = rep; step = st;
    was_empty = (pend.size() == 0);
    stv = 1'b0;
    if (ld) begin
      split(d, mode);
      m_hold = d;
      m_mode = mode;
      stv = was_empty && st;
    end else if (was_empty) begin
      stv = st;
    end else if (st) begin
      void'(pend.pop_front());
      if (pend.size() == 0 && rep) split(m_hold, m_mode);
    end
    v  = (pend.size() != 0);
    px = v ? pend[0] : 8'h00;
`ifdef BLIT_PATZERO_EN
    z  = v && (px == 8'h00);
`else
    z  = 1'b0;
`endif
    expq.push_back(pack(v, !v, stv, z, px));
  endtask

  task automatic check_reset_outputs(input string name);
    logic [11:0] act;
    act = pack(pixval, patreq, starve, patzero, pixd);
    checks++;
    if (act !== pack(1'b0, 1'b1, 1'b0, 1'b0, 8'h00)) begin
      errors++;
      $display("FAIL %s: got v/req/stv/z/pix=%b want 0/1/0/0/00", name, act);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare DUT outputs.
  initial begin
    logic [11:0] exp_v, act;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        exp_v = expq.pop_front();
        act   = pack(pixval, patreq, starve, patzero, pixd);
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL cycle@%0t: got v/req/stv/z/pix=%b want %b", $time, act, exp_v);
        end
      end
    end
  end

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rstl = 1'b0; patld = 1'b0; step = 1'b0;
    #1;
    check_reset_outputs(name);
    pend.delete();
    m_hold = 8'h00; m_mode = 2'b00;
    @(negedge clk);
    rstl = 1'b1;
  endtask

  initial begin
    rstl = 1'b0; patd = 8'h00; patld = 1'b0; pmode = 2'b00; patrep = 1'b0; step = 1'b0;
    m_hold = 8'h00; m_mode = 2'b00;
    #1;
    check_reset_outputs("reset_init");
    @(negedge clk);
    rstl = 1'b1;

    // 8bpp single pixel then empty
    @(negedge clk); drive(1, 8'hA5, 2'b00, 0, 0);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 0);
    // 2bpp 2,3,1,0
    @(negedge clk); drive(1, 8'hB4, 2'b10, 0, 0);
    for (int i = 0; i < 4; i++) begin @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1); end
    // 4bpp repeat
    @(negedge clk); drive(1, 8'h3C, 2'b01, 1, 0);
    for (int i = 0; i < 6; i++) begin @(negedge clk); drive(0, 8'h00, 2'b00, 1, 1); end
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    // back-to-back reload on last pixel
    @(negedge clk); drive(1, 8'h12, 2'b01, 0, 0);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    @(negedge clk); drive(1, 8'h9F, 2'b01, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    // starve, then load+step at CNT=2
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 0);
    @(negedge clk); drive(1, 8'h5A, 2'b01, 0, 1);
    @(negedge clk); drive(1, 8'hE7, 2'b10, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 0);
    // reset mid-byte in 2bpp, nothing resumes without a load
    @(negedge clk); drive(1, 8'hC9, 2'b10, 0, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 0, 1);
    pulse_reset("reset_midbyte");
    @(negedge clk); drive(0, 8'h00, 2'b00, 1, 1);
    @(negedge clk); drive(0, 8'h00, 2'b00, 1, 0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if (n % 397 == 396) begin
        pulse_reset("reset_random");
      end else begin
        @(negedge clk);
        drive(($urandom_range(0, 99) < 30), 8'($urandom), 2'($urandom),
              ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 70));
      end
    end

    @(negedge clk);
    patld = 1'b0; step = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/blit_patpix.md
# blit_patpix

Pattern pixel serializer for the blitter data path. It sits directly downstream of the pattern data register and consumes the latched byte PATD each time that register is loaded. It splits the byte into 8-, 4- or 2-bit pixels, most significant first, and presents one pixel per blitter write step. It raises a request when it needs the next pattern byte.

## Interface
Parameters:
- none.

Ports:
- MasterClock  in  1  system clock; all state changes on its rising edge.
- RESETL  in  1  reset, asynchronous and active-low.
- PATD  in  8  pattern byte from the pattern data register; must be stable whenever PATLD is high.
- PATLD  in  1  one-cycle pulse: PATD holds a newly loaded byte.
- PMODE  in  2  pixel mode: 00 = 8bpp, 01 = 4bpp, 10 = 2bpp, 11 = reserved (treated as 8bpp). Sampled only on PATLD.
- PATREP  in  1  repeat: on exhaustion, replay the held byte instead of emptying. Sampled every cycle.
- STEP  in  1  blitter consumes the current pixel this cycle.
- PIXD  out  8  current pixel, right-justified, zero-extended.
- PIXVAL  out  1  PIXD is valid.
- PATREQ  out  1  serializer is empty and wants a byte.
- STARVE  out  1  one-cycle pulse: STEP arrived while empty.
- PATZERO  out  1  current pixel equals zero. Present only with BLIT_PATZERO_EN.

## Operation
Registers:
- SR[7:0]: shift register.
- HOLD[7:0]: copy of the loaded byte.
- MODEQ[1:0]: mode sampled at load.
- CNT[2:0]: pixels remaining.
- State: EMPTY or FULL.

Behaviour by state and inputs:
- Pixels per byte (PPB): 8bpp = 1, 4bpp = 2, 2bpp = 4.
- EMPTY: PATREQ = 1, PIXVAL = 0, PIXD = 0.
- EMPTY, PATLD: SR = HOLD = PATD, MODEQ = PMODE, CNT = PPB, state goes to FULL.
- EMPTY, STEP without PATLD: STEP is ignored and STARVE pulses next cycle.
- EMPTY, PATLD and STEP together: the load happens, STEP is dropped and STARVE pulses.
- FULL: PIXVAL = 1, PATREQ = 0. PIXD is the pixel-width field at the top of SR:
  - 8bpp: SR[7:0].
  - 4bpp: {4'b0, SR[7:4]}.
  - 2bpp: {6'b0, SR[7:6]}.
- FULL, STEP, CNT > 1: SR shifts left by the pixel width with zero fill; CNT decrements.
- FULL, STEP, CNT == 1 (last pixel):
  - PATLD same cycle: reload from PATD (back-to-back, no bubble).
  - Else PATREP = 1: SR = HOLD, CNT = PPB(MODEQ), state stays FULL.
  - Else: state goes to EMPTY.
- FULL, PATLD (any CNT): reload from PATD; remaining pixels are discarded. PATLD has priority over STEP, and a same-cycle STEP is absorbed by the discarded byte with no STARVE.
- PMODE changes take effect only at the next PATLD. Repeat always uses MODEQ.

## Timing
Reset values:
- State EMPTY.
- SR, HOLD, CNT, MODEQ = 0.
- PIXD = 0, PIXVAL = 0, STARVE = 0, PATZERO = 0.
- PATREQ = 1; it is decoded from state, so it is high during reset.

Latency and throughput:
- PATLD in cycle N gives PIXVAL = 1 and the first pixel on PIXD in cycle N+1.
- Sustained rate is one pixel per cycle with STEP held high.
- A refill with no repeat costs one bubble cycle: last STEP in N, PATREQ = 1 in N+1, PATLD in N+1, PIXVAL in N+2.

Handshake:
- PATREQ is decoded from state (combinational); PIXD and PIXVAL come straight from registers.
- Asserting RESETL low mid-byte clears the state immediately and asynchronously. No pixel is emitted after reset deasserts until a PATLD occurs.

## Configuration
- BLIT_PATZERO_EN defined: the PATZERO output exists.
  - PATZERO = PIXVAL & (PIXD == 0), registered alongside PIXD.
  - The blitter uses it for transparent pattern pixels.
- BLIT_PATZERO_EN undefined: the PATZERO port and its logic are omitted. All other behaviour is identical.

## Test plan
- Reset, then PATLD with PATD = 8'hA5, PMODE = 00, STEP high: PIXD = 8'hA5 for one cycle, then PIXVAL = 0 and PATREQ = 1.
- PATD = 8'hB4, PMODE = 10, STEP held high: PIXD = 2, 3, 1, 0 in consecutive cycles. With BLIT_PATZERO_EN, PATZERO is high on the 4th pixel only.
- PATD = 8'h3C, PMODE = 01, PATREP = 1, STEP held for 6 cycles: PIXD = 3, C, 3, C, 3, C and PATREQ stays 0.
- PATD = 8'h12 in 4bpp, then PATLD of 8'h9F on the last-pixel STEP: PIXD = 1, 2, 9, F with no bubble.
- STEP while EMPTY: STARVE pulses exactly once and PIXVAL stays 0. Then PATLD with STEP in the same cycle while FULL at CNT = 2: the new byte's first pixel appears and no STARVE.
- RESETL pulsed low mid-byte in 2bpp: outputs return to reset values immediately, and nothing resumes until the next PATLD.
